// File: rtl/tone_decoder.sv
// tone_decoder: measures the half-period of a square-wave tone line and
// decodes it to one of the eight scale notes C4..C5 (codes 1..8). A note is
// reported only after STABLE consecutive matching half-periods; its start,
// end and duration are exposed so a played melody can be captured.
module tone_decoder #(
    parameter int HP_C4   = 191500,
    parameter int HP_D4   = 170000,
    parameter int HP_E4   = 151900,
    parameter int HP_F4   = 143200,
    parameter int HP_G4   = 127500,
    parameter int HP_A4   = 113600,
    parameter int HP_B4   = 101400,
    parameter int HP_C5   = 95600,
    parameter int TOL     = 2000,
    parameter int STABLE  = 4,
    parameter int TIMEOUT = 250000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        tone_in,
    output logic        note_valid,
    output logic [3:0]  note_code,
    output logic        note_start,
    output logic        note_end,
    output logic [31:0] note_dur,
    output logic [17:0] hp_meas
);
    localparam int CW = $clog2(TIMEOUT + 2);
    localparam int MW = $clog2(STABLE + 1);
    localparam int HP_TAB [8] = '{HP_C4, HP_D4, HP_E4, HP_F4,
                                  HP_G4, HP_A4, HP_B4, HP_C5};

    typedef enum logic [1:0] {IDLE, ARMED, LOCKING, LOCKED} state_t;

    state_t        state_q, state_d;
    logic          sync1_q, sync2_q, prev_q;
    logic          edge_det, timeout;
    logic [CW-1:0] hp_cnt_q, hp_cnt_d;
    logic [CW:0]   meas;
    logic [3:0]    code;
    logic [3:0]    cand_q, cand_d;
    logic [MW-1:0] match_q, match_d;
    logic          valid_q, valid_d;
    logic [3:0]    code_q, code_d;
    logic          start_q, start_d;
    logic          end_q, end_d;
    logic [31:0]   dur_q, dur_d;
    logic [17:0]   hpm_q, hpm_d;

    // Window match; iterating downwards lets the lowest code win on overlap.
    function automatic logic [3:0] classify(input int m);
        logic [3:0] c;
        c = 4'd0;
        for (int k = 7; k >= 0; k--)
            if (m >= HP_TAB[k] - TOL && m <= HP_TAB[k] + TOL) c = 4'(k + 1);
        return c;
    endfunction

    assign edge_det = sync2_q ^ prev_q;
    assign timeout  = (hp_cnt_q == CW'(TIMEOUT));
    assign meas     = {1'b0, hp_cnt_q} + (CW + 1)'(1);
    assign code     = classify(int'(meas));

    // Two-flop synchronizer plus previous-value flop for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= tone_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // State, counters and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            hp_cnt_q <= '0;
            cand_q   <= '0;
            match_q  <= '0;
            valid_q  <= 1'b0;
            code_q   <= '0;
            start_q  <= 1'b0;
            end_q    <= 1'b0;
            dur_q    <= '0;
            hpm_q    <= '0;
        end else begin
            state_q  <= state_d;
            hp_cnt_q <= hp_cnt_d;
            cand_q   <= cand_d;
            match_q  <= match_d;
            valid_q  <= valid_d;
            code_q   <= code_d;
            start_q  <= start_d;
            end_q    <= end_d;
            dur_q    <= dur_d;
            hpm_q    <= hpm_d;
        end
    end

    // Next-state: measure on each edge, track candidate note, lock and release.
    always_comb begin
        state_d  = state_q;
        cand_d   = cand_q;
        match_d  = match_q;
        valid_d  = valid_q;
        code_d   = code_q;
        start_d  = 1'b0;
        end_d    = 1'b0;
        dur_d    = dur_q;
        hpm_d    = hpm_q;
        hp_cnt_d = edge_det ? '0 : (timeout ? hp_cnt_q : hp_cnt_q + CW'(1));
        if (!en) begin
            state_d  = IDLE;
            hp_cnt_d = '0;
            cand_d   = '0;
            match_d  = '0;
            valid_d  = 1'b0;
            code_d   = '0;
            end_d    = (state_q == LOCKED);
        end else begin
            if (state_q == LOCKED && dur_q != 32'hFFFF_FFFF) dur_d = dur_q + 32'd1;
            // The arming edge has no preceding edge, so it yields no measurement.
            if (edge_det && state_q != IDLE) hpm_d = 18'(meas);
            unique case (state_q)
                IDLE: if (edge_det) state_d = ARMED;
                ARMED: begin
                    if (edge_det) begin
                        if (code != 4'd0) begin
                            state_d = LOCKING;
                            cand_d  = code;
                            match_d = MW'(1);
                        end
                    end else if (timeout) state_d = IDLE;
                end
                LOCKING: begin
                    if (edge_det) begin
                        if (code == 4'd0) begin
                            state_d = ARMED;
                            match_d = '0;
                        end else if (code == cand_q) begin
                            match_d = match_q + MW'(1);
                            if (match_q == MW'(STABLE - 1)) begin
                                state_d = LOCKED;
                                start_d = 1'b1;
                                valid_d = 1'b1;
                                code_d  = cand_q;
                                dur_d   = '0;
                            end
                        end else begin
                            cand_d  = code;
                            match_d = MW'(1);
                        end
                    end else if (timeout) begin
                        state_d = IDLE;
                        match_d = '0;
                    end
                end
                LOCKED: begin
                    if (edge_det) begin
                        if (code != cand_q) begin
                            end_d   = 1'b1;
                            valid_d = 1'b0;
                            code_d  = '0;
                            cand_d  = code;
                            match_d = (code != 4'd0) ? MW'(1) : '0;
                            state_d = (code != 4'd0) ? LOCKING : ARMED;
                        end
                    end else if (timeout) begin
                        end_d   = 1'b1;
                        valid_d = 1'b0;
                        code_d  = '0;
                        match_d = '0;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign note_valid = valid_q;
    assign note_code  = code_q;
    assign note_start = start_q;
    assign note_end   = end_q;
    assign note_dur   = dur_q;
    assign hp_meas    = hpm_q;
endmodule

// File: tb/tb_tone_decoder.sv
// Bench for tone_decoder with half-periods scaled down so whole melodies fit
// in a short run. The reference model works on the list of gaps between tone
// toggles and predicts note start/end events, durations and hp_meas.
module tb_tone_decoder;
    localparam int T    = 250;
    localparam int STB  = 4;
    localparam int TOL  = 2;
    localparam int HPS [8] = '{192, 170, 152, 143, 128, 114, 101, 96};
    localparam int OFFS [5] = '{110, 135, 160, 181, 120};

    logic        clk = 1'b0, rst_n = 1'b0, en = 1'b0, tone_in = 1'b0;
    logic        note_valid, note_start, note_end;
    logic [3:0]  note_code;
    logic [31:0] note_dur;
    logic [17:0] hp_meas;

    tone_decoder #(
        .HP_C4(HPS[0]), .HP_D4(HPS[1]), .HP_E4(HPS[2]), .HP_F4(HPS[3]),
        .HP_G4(HPS[4]), .HP_A4(HPS[5]), .HP_B4(HPS[6]), .HP_C5(HPS[7]),
        .TOL(TOL), .STABLE(STB), .TIMEOUT(T)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .tone_in(tone_in),
        .note_valid(note_valid), .note_code(note_code), .note_start(note_start),
        .note_end(note_end), .note_dur(note_dur), .hp_meas(hp_meas)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { bit st; int code; longint dur; longint cyc; } ev_t;
    ev_t    ev_q[$], exp_q[$];
    int     stim[$];
    longint first_tog, last_tog;
    int     exp_hp = 0;
    int     n_cmp = 0, n_bad = 0;

    // Event capture: one record per note_start / note_end pulse.
    always @(negedge clk) begin
        ev_t e;
        if (rst_n && note_start) begin
            e.st = 1'b1; e.code = int'(note_code); e.dur = 0; e.cyc = cyc;
            ev_q.push_back(e);
        end
        if (rst_n && note_end) begin
            e.st = 1'b0; e.code = 0; e.dur = longint'(note_dur); e.cyc = cyc;
            ev_q.push_back(e);
        end
    end

    initial begin
        #(10 * 80000);
        $display("FAIL watchdog: simulation exceeded cycle budget, expected completion");
        $fatal(1, "watchdog");
    end

    function automatic int ref_code(input int g);
        for (int k = 0; k < 8; k++)
            if (g >= HPS[k] - TOL && g <= HPS[k] + TOL) return k + 1;
        return 0;
    endfunction

    // Event-level model: a gap longer than T+1 is silence (the decoder times
    // out); otherwise each gap is a measurement. STB equal nonzero codes in a
    // row lock a note; a different code or silence ends it.
    function automatic void model(input bit tail);
        int cand, run, g, c;
        bit locked;
        longint dur;
        ev_t e;
        cand = 0; run = 0; locked = 0; dur = 0;
        exp_q.delete();
        foreach (stim[i]) begin
            g = stim[i];
            if (g > T + 1) begin
                if (locked) begin
                    dur += T + 1;
                    e.st = 0; e.code = 0; e.dur = dur; e.cyc = 0; exp_q.push_back(e);
                end
                locked = 0; cand = 0; run = 0;
            end else begin
                c = ref_code(g);
                exp_hp = g;
                if (locked) begin
                    dur += g;
                    if (c != cand) begin
                        e.st = 0; e.code = 0; e.dur = dur; e.cyc = 0; exp_q.push_back(e);
                        locked = 0; cand = c; run = (c != 0) ? 1 : 0;
                    end
                end else if (c == 0) begin
                    cand = 0; run = 0;
                end else if (c == cand) begin
                    run++;
                end else begin
                    cand = c; run = 1;
                end
                if (!locked && run == STB) begin
                    locked = 1; dur = 0;
                    e.st = 1; e.code = cand; e.dur = 0; e.cyc = 0; exp_q.push_back(e);
                end
            end
        end
        if (tail && locked) begin
            dur += T + 1;
            e.st = 0; e.code = 0; e.dur = dur; e.cyc = 0; exp_q.push_back(e);
        end
    endfunction

    // Plays stim as toggle gaps (first toggle arms), optionally followed by silence.
    task automatic drive(input bit tail);
        @(negedge clk);
        tone_in = ~tone_in; first_tog = cyc; last_tog = cyc;
        foreach (stim[i]) begin
            repeat (stim[i]) @(negedge clk);
            tone_in = ~tone_in; last_tog = cyc;
        end
        if (tail) repeat (T + 30) @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        en = 1'b1; rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if ({note_valid, note_code, note_start, note_end, note_dur, hp_meas} !== '0) begin
            n_bad++;
            $display("FAIL reset_in: valid=%0b code=%0d dur=%0d hp=%0d, required all 0",
                     note_valid, note_code, note_dur, hp_meas);
        end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        n_cmp++;
        if ({note_valid, note_code, note_start, note_end, note_dur, hp_meas} !== '0) begin
            n_bad++;
            $display("FAIL reset_out: valid=%0b code=%0d dur=%0d hp=%0d, required all 0",
                     note_valid, note_code, note_dur, hp_meas);
        end
        exp_hp = 0;
    endtask

    task automatic test_lock_g4();
        ev_q.delete(); stim.delete();
        repeat (6) stim.push_back(128);
        drive(0);
        repeat (5) @(negedge clk);
        #1;
        n_cmp++;
        if (note_valid !== 1'b1 || note_code !== 4'd5 || hp_meas !== 18'd128) begin
            n_bad++;
            $display("FAIL g4_locked: valid=%0b code=%0d hp=%0d, required 1/5/128",
                     note_valid, note_code, hp_meas);
        end
        n_cmp++;
        if (ev_q.size() < 1 || ev_q[0].cyc !== first_tog + 4 * 128 + 3) begin
            n_bad++;
            $display("FAIL g4_latency: start at %0d, required %0d",
                     (ev_q.size() > 0) ? ev_q[0].cyc - first_tog : -1, 4 * 128 + 3);
        end
        repeat (T + 30) @(negedge clk);
        #1;
        model(1);
        n_cmp++;
        if (ev_q.size() != exp_q.size()) begin
            n_bad++;
            $display("FAIL g4_events: got %0d events, required %0d", ev_q.size(), exp_q.size());
        end else foreach (exp_q[i]) begin
            n_cmp++;
            if (ev_q[i].st !== exp_q[i].st || ev_q[i].code !== exp_q[i].code || ev_q[i].dur !== exp_q[i].dur) begin
                n_bad++;
                $display("FAIL g4_ev%0d: got st=%0d code=%0d dur=%0d, required st=%0d code=%0d dur=%0d",
                         i, ev_q[i].st, ev_q[i].code, ev_q[i].dur, exp_q[i].st, exp_q[i].code, exp_q[i].dur);
            end
        end
    endtask

    task automatic test_note_change();
        ev_q.delete(); stim.delete();
        repeat (5) stim.push_back(192);
        repeat (5) stim.push_back(152);
        drive(1);
        model(1);
        n_cmp++;
        if (ev_q.size() != exp_q.size()) begin
            n_bad++;
            $display("FAIL change_events: got %0d events, required %0d", ev_q.size(), exp_q.size());
        end else foreach (exp_q[i]) begin
            n_cmp++;
            if (ev_q[i].st !== exp_q[i].st || ev_q[i].code !== exp_q[i].code || ev_q[i].dur !== exp_q[i].dur) begin
                n_bad++;
                $display("FAIL change_ev%0d: got st=%0d code=%0d dur=%0d, required st=%0d code=%0d dur=%0d",
                         i, ev_q[i].st, ev_q[i].code, ev_q[i].dur, exp_q[i].st, exp_q[i].code, exp_q[i].dur);
            end
        end
    endtask

    task automatic test_timeout();
        longint dt;
        ev_q.delete(); stim.delete();
        repeat (5) stim.push_back(114);
        drive(1);
        model(1);
        dt = (ev_q.size() == 2) ? ev_q[1].cyc - last_tog : -1;
        n_cmp++;
        if (ev_q.size() != 2 || ev_q[1].st !== 1'b0 || dt < T || dt > T + 4) begin
            n_bad++;
            $display("FAIL timeout_end: %0d events, end %0d cycles after last toggle, required 2 events and %0d..%0d",
                     ev_q.size(), dt, T, T + 4);
        end
        n_cmp++;
        if (exp_q.size() != 2 || ev_q.size() != 2 || ev_q[1].dur !== exp_q[1].dur) begin
            n_bad++;
            $display("FAIL timeout_dur: got %0d events, required dur %0d",
                     ev_q.size(), (exp_q.size() == 2) ? exp_q[1].dur : -1);
        end
        repeat (40) @(negedge clk);
        #1;
        n_cmp++;
        if (note_valid !== 1'b0 || note_code !== 4'd0 || exp_q.size() != 2 || longint'(note_dur) !== exp_q[1].dur) begin
            n_bad++;
            $display("FAIL timeout_hold: valid=%0b code=%0d dur=%0d, required 0/0/held %0d",
                     note_valid, note_code, note_dur, (exp_q.size() == 2) ? exp_q[1].dur : -1);
        end
    endtask

    task automatic test_off_tone();
        ev_q.delete(); stim.delete();
        repeat (8) stim.push_back(110);
        drive(1);
        model(1);
        n_cmp++;
        if (ev_q.size() != 0 || note_code !== 4'd0 || hp_meas !== 18'(exp_hp)) begin
            n_bad++;
            $display("FAIL off_tone: events=%0d code=%0d hp=%0d, required 0/0/%0d",
                     ev_q.size(), note_code, hp_meas, exp_hp);
        end
    endtask

    task automatic test_no_lock();
        ev_q.delete(); stim.delete();
        repeat (5) begin stim.push_back(128); stim.push_back(114); end
        repeat (3) stim.push_back(128);
        stim.push_back(140);
        drive(1);
        model(1);
        n_cmp++;
        if (ev_q.size() != 0 || exp_q.size() != 0 || hp_meas !== 18'd140) begin
            n_bad++;
            $display("FAIL no_lock: events=%0d model=%0d hp=%0d, required 0/0/140",
                     ev_q.size(), exp_q.size(), hp_meas);
        end
    endtask

    // Window edges: HP+TOL and HP-TOL match, HP+TOL+1 does not.
    task automatic test_boundary();
        ev_q.delete(); stim.delete();
        repeat (5) stim.push_back(128 + TOL);
        repeat (3) stim.push_back(128 + TOL + 1);
        repeat (5) stim.push_back(96 - TOL);
        drive(1);
        model(1);
        n_cmp++;
        if (ev_q.size() != exp_q.size()) begin
            n_bad++;
            $display("FAIL bound_events: got %0d events, required %0d", ev_q.size(), exp_q.size());
        end else foreach (exp_q[i]) begin
            n_cmp++;
            if (ev_q[i].st !== exp_q[i].st || ev_q[i].code !== exp_q[i].code || ev_q[i].dur !== exp_q[i].dur) begin
                n_bad++;
                $display("FAIL bound_ev%0d: got st=%0d code=%0d dur=%0d, required st=%0d code=%0d dur=%0d",
                         i, ev_q[i].st, ev_q[i].code, ev_q[i].dur, exp_q[i].st, exp_q[i].code, exp_q[i].dur);
            end
        end
    endtask

    task automatic test_random();
        int r, k, len;
        for (int it = 0; it < 3; it++) begin
            ev_q.delete(); stim.delete();
            while (stim.size() < 24) begin
                r = int'($urandom_range(0, 9));
                if (r < 7) begin
                    k = int'($urandom_range(0, 7));
                    len = int'($urandom_range(1, 6));
                    repeat (len) stim.push_back(HPS[k] + int'($urandom_range(0, 2 * TOL)) - TOL);
                end else if (r < 9) begin
                    stim.push_back(OFFS[$urandom_range(0, 4)]);
                end else begin
                    stim.push_back(T + 50);
                end
            end
            drive(1);
            model(1);
            n_cmp++;
            if (ev_q.size() != exp_q.size()) begin
                n_bad++;
                $display("FAIL rand%0d_events: got %0d events, required %0d", it, ev_q.size(), exp_q.size());
            end else foreach (exp_q[i]) begin
                n_cmp++;
                if (ev_q[i].st !== exp_q[i].st || ev_q[i].code !== exp_q[i].code || ev_q[i].dur !== exp_q[i].dur) begin
                    n_bad++;
                    $display("FAIL rand%0d_ev%0d: got st=%0d code=%0d dur=%0d, required st=%0d code=%0d dur=%0d",
                             it, i, ev_q[i].st, ev_q[i].code, ev_q[i].dur, exp_q[i].st, exp_q[i].code, exp_q[i].dur);
                end
            end
            n_cmp++;
            if (hp_meas !== 18'(exp_hp)) begin
                n_bad++;
                $display("FAIL rand%0d_hp: got %0d, required %0d", it, hp_meas, exp_hp);
            end
        end
    endtask

    task automatic test_enable_drop();
        longint s, lock_cyc;
        ev_q.delete(); stim.delete();
        repeat (5) stim.push_back(170);
        drive(0);
        lock_cyc = first_tog + 4 * 170 + 3;
        repeat (50) @(negedge clk);
        en = 1'b0; s = cyc;
        @(negedge clk);
        en = 1'b1;
        #1;
        n_cmp++;
        if (ev_q.size() != 2 || ev_q[0].cyc !== lock_cyc || ev_q[1].st !== 1'b0 || ev_q[1].dur !== s - lock_cyc) begin
            n_bad++;
            $display("FAIL en_end: events=%0d end_dur=%0d, required 2 events, dur %0d",
                     ev_q.size(), (ev_q.size() > 1) ? ev_q[1].dur : -1, s - lock_cyc);
        end
        n_cmp++;
        if (note_end !== 1'b1 || note_valid !== 1'b0 || note_code !== 4'd0) begin
            n_bad++;
            $display("FAIL en_outputs: end=%0b valid=%0b code=%0d, required 1/0/0", note_end, note_valid, note_code);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (note_end !== 1'b0 || longint'(note_dur) !== s - lock_cyc) begin
            n_bad++;
            $display("FAIL en_pulse: end=%0b dur=%0d, required 0 and held %0d", note_end, note_dur, s - lock_cyc);
        end
        // Continue the D4 wave on its original grid.
        repeat (int'(last_tog + 170 - cyc)) @(negedge clk);
        tone_in = ~tone_in;
        repeat (3) begin
            repeat (170) @(negedge clk);
            tone_in = ~tone_in;
        end
        repeat (10) @(negedge clk);
        #1;
        n_cmp++;
        if (ev_q.size() != 2) begin
            n_bad++;
            $display("FAIL en_early: %0d events after 4 edges, required 2", ev_q.size());
        end
        repeat (160) @(negedge clk);
        tone_in = ~tone_in;
        repeat (5) @(negedge clk);
        #1;
        n_cmp++;
        if (ev_q.size() != 3 || ev_q[2].code != 2 || note_valid !== 1'b1 || hp_meas !== 18'd170) begin
            n_bad++;
            $display("FAIL en_relock: events=%0d valid=%0b hp=%0d, required 3 events code 2, 1/170",
                     ev_q.size(), note_valid, hp_meas);
        end
        repeat (60) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({note_valid, note_code, note_start, note_end, note_dur, hp_meas} !== '0) begin
            n_bad++;
            $display("FAIL rst_mid: valid=%0b code=%0d dur=%0d hp=%0d, required all 0",
                     note_valid, note_code, note_dur, hp_meas);
        end
        tone_in = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        n_cmp++;
        if (ev_q.size() != 3 || note_end !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_no_end: events=%0d end=%0b, required 3/0", ev_q.size(), note_end);
        end
        exp_hp = 0;
    endtask

    initial begin
        test_reset();
        test_lock_g4();
        test_note_change();
        test_timeout();
        test_off_tone();
        test_no_lock();
        test_boundary();
        test_random();
        test_enable_drop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
